instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch stage of the 16-bit CPU. Owns the PC and issues word fetches to
//   instruction memory over a req/rdy handshake. Holds the fetched instruction stable
//   for the execute path and drives OPCODE into the control unit. Advances the PC by 2,
//   or to the beq target, once the execute path signals completion.
// PARAMETERS
//   ADDR_W    16       PC / instruction-memory byte-address width
//   RESET_PC  16'h0000 PC value loaded on reset
// PORTS
//   Clk          in   1       clock; all state updates on rising edge
//   Reset        in   1       synchronous, active-high reset
//   IMemReq      out  1       fetch request to instruction memory
//   IMemAddr     out  ADDR_W  fetch byte address (= PC)
//   IMemRdy      in   1       memory returns IMemData this cycle (sampled only while IMemReq=1)
//   IMemData     in   16      instruction word from memory
//   Instr        out  16      held instruction register
//   OPCODE       out  4       Instr[15:12], to control unit
//   InstrValid   out  1       Instr is a legal instruction awaiting execution
//   ExecDone     in   1       execute path retires held instruction this cycle
//   BranchTaken  in   1       Branch & ALU zero for held instruction; qualified by ExecDone
//   PC           out  ADDR_W  address of held/in-flight instruction
//   PCPlus2      out  ADDR_W  PC + 2, modulo 2^ADDR_W (combinational)
//   Halted       out  1       illegal opcode fetched; fetch stopped
// BEHAVIOUR
// - Reset (sync, Reset=1 at edge): state=IDLE, PC=RESET_PC, Instr=16'h0000,
//   InstrValid=0, Halted=0, IMemReq=0. Reset overrides every other input on that edge,
//   including IMemRdy/ExecDone, and aborts any fetch or execute in progress.
// - OPCODE=0000 after reset is a decodable opcode; consumers gate writes with InstrValid.
// - FSM states: IDLE, FETCH, EXEC, HALT.
//   IDLE : IMemReq=0; unconditionally -> FETCH next cycle.
//   FETCH: IMemReq=1, IMemAddr=PC held stable until IMemRdy=1 (any number of wait cycles).
//     On the IMemRdy=1 edge, Instr<=IMemData.
//     If IMemData[15:12] is legal -> EXEC with InstrValid=1. Otherwise -> HALT.
//     Legal opcodes: 0000, 0001, 0010, 1001, 1010, 1011, 1100, 1101, 1111.
//     ExecDone/BranchTaken are ignored in FETCH.
//   EXEC : IMemReq=0; Instr/OPCODE/PC stable; InstrValid=1. On ExecDone=1 edge:
//     if BranchTaken=1 and Instr[15:12]==4'b1111: PC <= PCPlus2 + (sext(Instr[7:0]) << 1).
//     Otherwise PC <= PCPlus2; BranchTaken on a non-beq opcode is ignored.
//     On the same edge, InstrValid<=0 and the FSM -> FETCH.
//   HALT : IMemReq=0, InstrValid=0, Halted=1; Instr keeps the offending word.
//     Remains in HALT until Reset.
// - Arithmetic: all PC math is ADDR_W bits, wraps modulo 2^ADDR_W, no overflow flag.
//   Immediate is sign-extended from 8 bits to ADDR_W before the shift.
// - Latency: fetch-to-InstrValid = 1 cycle after the IMemRdy edge. The minimum loop is
//   2 cycles per instruction: IMemRdy=1 in the first FETCH cycle, then ExecDone in the
//   first EXEC cycle. The IDLE cycle occurs only after reset.
// - IMemAddr is driven from PC in every state; it is meaningful only while IMemReq=1.
// TESTING
//   T1 Reset, IMemRdy=1 always, IMemData=16'h1234.
//      -> Cycle 1: IMemReq=0. Cycle 2: IMemReq=1, IMemAddr=0x0000.
//      -> Cycle 3: InstrValid=1, OPCODE=4'h1. Pulse ExecDone -> PC=0x0002, IMemReq=1.
//   T2 IMemRdy low for 3 FETCH cycles at PC=0x0004.
//      -> IMemAddr=0x0004 stable, InstrValid=0 throughout. Captures on 4th cycle.
//   T3 PC=0x0010, Instr=16'hF0FE, ExecDone=1, BranchTaken=1 -> PC=0x000E.
//      PC=0xFFFE, Instr=16'hF07F, same stimulus -> PC=0x00FE (wrap).
//   T4 Instr=16'h1234, ExecDone=1, BranchTaken=1 at PC=0x0020 -> PC=0x0022 (branch ignored).
//   T5 IMemData=16'h7000 captured -> Halted=1, InstrValid=0, IMemReq=0.
//      Stays halted for 20 cycles with IMemRdy=1 and ExecDone toggling; Reset clears it.
//   T6 Reset during a FETCH wait (IMemRdy=0), or in EXEC with ExecDone=1 on the same edge.
//      -> Next cycle: PC=RESET_PC, InstrValid=0, IMemReq=0, Instr=16'h0000.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: owns the PC, fetches over req/rdy, holds Instr
// Advances the PC by 2 or to the beq target when the execute path retires the held word.
module instr_fetch #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clk,
   input  logic              Reset,
   output logic              IMemReq,
   output logic [ADDR_W-1:0] IMemAddr,
   input  logic              IMemRdy,
   input  logic [15:0]       IMemData,
   output logic [15:0]       Instr,
   output logic [3:0]        OPCODE,
   output logic              InstrValid,
   input  logic              ExecDone,
   input  logic              BranchTaken,
   output logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] PCPlus2,
   output logic              Halted
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_instr;
   logic              w_capture;
   logic              w_retire;
   logic              w_legal;
   logic              w_take_branch;
   logic [ADDR_W-1:0] w_pc_plus2;
   logic [ADDR_W-1:0] w_imm_sext;
   logic [ADDR_W-1:0] w_branch_target;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b1010,
         4'b1011, 4'b1100, 4'b1101, 4'b1111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   assign w_legal         = is_legal(IMemData[15:12]);
   assign w_capture       = (r_state == S_FETCH) && IMemRdy;
   assign w_retire        = (r_state == S_EXEC) && ExecDone;
   // Only beq (1111) may redirect; BranchTaken on any other opcode is ignored.
   assign w_take_branch   = BranchTaken && (r_instr[15:12] == 4'b1111);
   assign w_pc_plus2      = r_pc + ADDR_W'(2);
   assign w_imm_sext      = {{(ADDR_W-8){r_instr[7]}}, r_instr[7:0]};
   assign w_branch_target = w_pc_plus2 + (w_imm_sext << 1);

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  w_next_state = S_FETCH;
         S_FETCH: if (IMemRdy) w_next_state = w_legal ? S_EXEC : S_HALT;
         S_EXEC:  if (ExecDone) w_next_state = S_FETCH;
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      IMemReq    = 1'b0;
      InstrValid = 1'b0;
      Halted     = 1'b0;
      case (r_state)
         S_FETCH: IMemReq    = 1'b1;
         S_EXEC:  InstrValid = 1'b1;
         S_HALT:  Halted     = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pc    <= RESET_PC;
         r_instr <= 16'h0000;
      end else begin
         if (w_capture) r_instr <= IMemData;
         if (w_retire)  r_pc    <= w_take_branch ? w_branch_target : w_pc_plus2;
      end
   end

   assign IMemAddr = r_pc;
   assign PC       = r_pc;
   assign PCPlus2  = w_pc_plus2;
   assign Instr    = r_instr;
   assign OPCODE   = r_instr[15:12];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a directed program
// Stimulus pushes expected {PC, Instr, halt} per fetch; a negedge monitor pops on each new instruction.
module tb_instr_fetch;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        IMemReq;
   logic [15:0] IMemAddr;
   logic        IMemRdy = 1'b0;
   logic [15:0] IMemData;
   logic [15:0] Instr;
   logic [3:0]  OPCODE;
   logic        InstrValid;
   logic        ExecDone = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [15:0] PC;
   logic [15:0] PCPlus2;
   logic        Halted;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
      logic        halt;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   logic prev_valid = 1'b0;
   logic prev_halt  = 1'b0;

   instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .Clk(Clk), .Reset(Reset),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdy(IMemRdy), .IMemData(IMemData),
      .Instr(Instr), .OPCODE(OPCODE), .InstrValid(InstrValid),
      .ExecDone(ExecDone), .BranchTaken(BranchTaken),
      .PC(PC), .PCPlus2(PCPlus2), .Halted(Halted)
   );

   always #5 Clk = ~Clk;

   // Program image laid out so the branch chain visits 0x10, 0x0E, 0xFFFE, 0x00FE, 0x20.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h1234;
         16'h0002: return 16'h2000;
         16'h0004: return 16'h9000;
         16'h0006: return 16'hF004;
         16'h0010: return 16'hF0FE;
         16'h000E: return 16'hF0F7;
         16'hFFFE: return 16'hF07F;
         16'h00FE: return 16'hF090;
         16'h0020: return 16'h1234;
         16'h0022: return 16'h7000;
         default:  return 16'h0000;
      endcase
   endfunction

   always_comb IMemData = mem_word(IMemAddr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if ((InstrValid && !prev_valid) || (Halted && !prev_halt)) begin
         if (q.size() == 0) begin
            check("sb_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            check("sb_pc", {16'h0, PC}, {16'h0, mon_e.pc});
            check("sb_instr", {16'h0, Instr}, {16'h0, mon_e.instr});
            check("sb_opcode", {28'h0, OPCODE}, {28'h0, mon_e.instr[15:12]});
            check("sb_halt", {31'h0, Halted}, {31'h0, mon_e.halt});
            check("sb_req", {31'h0, IMemReq}, 32'd0);
         end
      end
      prev_valid = InstrValid;
      prev_halt  = Halted;
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"},    {16'h0, PC},     32'h0);
      check({tag, "_instr"}, {16'h0, Instr},  32'h0);
      check({tag, "_valid"}, {31'h0, InstrValid}, 32'd0);
      check({tag, "_req"},   {31'h0, IMemReq},    32'd0);
      check({tag, "_halt"},  {31'h0, Halted},     32'd0);
   endtask

   task automatic do_reset(input string tag);
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0; IMemRdy = 1'b0; ExecDone = 1'b0; BranchTaken = 1'b0;
      check_reset_state(tag);
   endtask

   // Entered with the DUT in FETCH; returns in the following FETCH (or in HALT).
   task automatic do_instr(input int waits, input logic bt, input logic [15:0] pc,
                           input logic [15:0] ins, input logic halt);
      logic [15:0] p2;
      p2 = pc + 16'd2;
      check("fetch_req", {31'h0, IMemReq}, 32'd1);
      check("fetch_addr", {16'h0, IMemAddr}, {16'h0, pc});
      q.push_back('{pc: pc, instr: ins, halt: halt});
      IMemRdy = 1'b0;
      for (int i = 0; i < waits; i++) begin
         @(posedge Clk); #1;
         check("wait_req", {31'h0, IMemReq}, 32'd1);
         check("wait_addr", {16'h0, IMemAddr}, {16'h0, pc});
         check("wait_valid", {31'h0, InstrValid}, 32'd0);
      end
      IMemRdy = 1'b1;
      @(posedge Clk); #1;
      IMemRdy = 1'b0;
      if (!halt) begin
         check("lat_valid", {31'h0, InstrValid}, 32'd1);
         check("exec_req", {31'h0, IMemReq}, 32'd0);
         check("exec_pcplus2", {16'h0, PCPlus2}, {16'h0, p2});
         ExecDone = 1'b1; BranchTaken = bt;
         @(posedge Clk); #1;
         ExecDone = 1'b0; BranchTaken = 1'b0;
         check("retire_valid", {31'h0, InstrValid}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge Clk); #1;
      do_reset("rst0");

      // T1: IDLE cycle, then fetch from 0 with no wait states.
      check("t1_idle_req", {31'h0, IMemReq}, 32'd0);
      IMemRdy = 1'b1;
      @(posedge Clk); #1;
      do_instr(0, 1'b0, 16'h0000, 16'h1234, 1'b0);
      do_instr(0, 1'b1, 16'h0002, 16'h2000, 1'b0);
      // T2: three wait cycles at 0x0004.
      do_instr(3, 1'b0, 16'h0004, 16'h9000, 1'b0);
      // T3: beq chain, including negative offset and address wrap.
      do_instr(0, 1'b1, 16'h0006, 16'hF004, 1'b0);
      do_instr(0, 1'b1, 16'h0010, 16'hF0FE, 1'b0);
      do_instr(0, 1'b1, 16'h000E, 16'hF0F7, 1'b0);
      do_instr(0, 1'b1, 16'hFFFE, 16'hF07F, 1'b0);
      do_instr(0, 1'b1, 16'h00FE, 16'hF090, 1'b0);
      // T4: BranchTaken on a non-beq opcode.
      do_instr(0, 1'b1, 16'h0020, 16'h1234, 1'b0);
      // T5: illegal opcode halts fetch.
      do_instr(0, 1'b0, 16'h0022, 16'h7000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         IMemRdy = 1'b1; ExecDone = i[0]; BranchTaken = 1'b1;
         check("halt_flag", {31'h0, Halted}, 32'd1);
         check("halt_valid", {31'h0, InstrValid}, 32'd0);
         check("halt_req", {31'h0, IMemReq}, 32'd0);
         check("halt_pc", {16'h0, PC}, 32'h0022);
         check("halt_instr", {16'h0, Instr}, 32'h7000);
         @(posedge Clk); #1;
      end
      do_reset("rst_halt");

      // T6a: reset wins over IMemRdy during a fetch wait.
      @(posedge Clk); #1;
      check("t6a_req", {31'h0, IMemReq}, 32'd1);
      @(posedge Clk); #1;
      IMemRdy = 1'b1;
      do_reset("rst_fetch");

      // T6b: reset wins over ExecDone/BranchTaken in EXEC.
      @(posedge Clk); #1;
      q.push_back('{pc: 16'h0000, instr: 16'h1234, halt: 1'b0});
      IMemRdy = 1'b1;
      @(posedge Clk); #1;
      IMemRdy = 1'b0;
      check("t6b_valid", {31'h0, InstrValid}, 32'd1);
      ExecDone = 1'b1; BranchTaken = 1'b1;
      do_reset("rst_exec");

      @(negedge Clk);
      check("sb_drain", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
